// File: rtl/stall_ctrl.sv
// rtl/stall_ctrl.sv - F/D hazard and mult/div stall sequencer with saturating stall counter
module stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rsD,
  input  logic [4:0]  rtD,
  input  logic [1:0]  tuse_rsD,
  input  logic [1:0]  tuse_rtD,
  input  logic        md_instrD,
  input  logic [4:0]  a3E,
  input  logic [1:0]  tnewE,
  input  logic [4:0]  a3M,
  input  logic [1:0]  tnewM,
  input  logic        md_startE,
  input  logic        md_is_divE,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_clr,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  // Reload values are sized to the 4-bit busy counter.
  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  logic [3:0]  busy_cnt_q, busy_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        stall_rs, stall_rt, stall_md, stall;

  // Data hazards: D needs a source earlier than the producer in E or M can forward it.
  // Register 0 is hardwired, so it never creates a dependency.
  always_comb begin
    stall_rs = 1'b0;
    stall_rt = 1'b0;
    if (rsD != 5'd0) begin
      stall_rs = ((rsD == a3E) && (tuse_rsD < tnewE)) ||
                 ((rsD == a3M) && (tuse_rsD < tnewM));
    end
    if (rtD != 5'd0) begin
      stall_rt = ((rtD == a3E) && (tuse_rtD < tnewE)) ||
                 ((rtD == a3M) && (tuse_rtD < tnewM));
    end
  end

  // MD hazard: a start in E counts as busy already, so an MD op entering D that cycle waits.
  always_comb begin
    md_busy  = (busy_cnt_q != 4'd0) || md_startE;
    stall_md = md_instrD && md_busy;
    stall    = stall_rs || stall_rt || stall_md;
  end

  // Pipeline control: hold PC and IF/ID, inject a bubble into ID/EX.
  always_comb begin
    pc_en     = !stall;
    ifid_en   = !stall;
    idex_clr  = stall;
    stall_cnt = stall_cnt_q;
  end

  // Next state: busy window reload/decrement and saturating stall count.
  // A start while still busy simply reloads; legal code never does this.
  always_comb begin
    busy_cnt_d  = busy_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (md_startE) begin
      busy_cnt_d = md_is_divE ? DIV_LOAD : MULT_LOAD;
    end else if (busy_cnt_q != 4'd0) begin
      busy_cnt_d = busy_cnt_q - 4'd1;
    end
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // State register; reset also aborts any in-flight mult/div window.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_cnt_q  <= 4'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      busy_cnt_q  <= busy_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: doc/stall_ctrl.md
Name: stall_ctrl

Overview:
- Hazard and stall sequencer for the 5-stage pipeline.
- Decides each cycle whether the F/D boundary holds: drives the PC write enable, the IF/ID register enable and the ID/EX flush.
- Stall sources: register data hazards (Tuse/Tnew comparison against E and M stages) and the multi-cycle multiply/divide unit, whose busy time it tracks with an internal down-counter.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start.
- DIV_CYCLES, 10, busy cycles after a div/divu start.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- rsD  input  5  rs field of instruction in D.
- rtD  input  5  rt field of instruction in D.
- tuse_rsD  input  2  cycles until D needs rs (3 = not used).
- tuse_rtD  input  2  cycles until D needs rt (3 = not used).
- md_instrD  input  1  D holds mult/div/mfhi/mflo/mthi/mtlo.
- a3E  input  5  destination register of instruction in E.
- tnewE  input  2  cycles until E result is forwardable.
- a3M  input  5  destination register of instruction in M.
- tnewM  input  2  cycles until M result is forwardable.
- md_startE  input  1  E holds mult/multu/div/divu this cycle.
- md_is_divE  input  1  qualifies md_startE: 1 = div, 0 = mult.
- pc_en  output  1  PC register write enable.
- ifid_en  output  1  IF/ID register enable.
- idex_clr  output  1  synchronous clear of ID/EX (bubble insert).
- md_busy  output  1  mult/div unit busy.
- stall_cnt  output  32  total stalled cycles since reset, saturating.

Behaviour:
- State:
  - busy_cnt: 4-bit down-counter.
  - stall_cnt: 32-bit counter.
- Reset (reset=1 at posedge): busy_cnt=0, stall_cnt=0.
  - Outputs during and after reset with idle inputs: pc_en=1, ifid_en=1, idex_clr=0, md_busy=0, stall_cnt=0.
  - Reset mid mult/div aborts the busy window immediately.
- Data hazard, combinational:
  - stall_rs = (rsD!=0) && ((rsD==a3E && tuse_rsD<tnewE) || (rsD==a3M && tuse_rsD<tnewM)).
  - stall_rt is the same with rtD and tuse_rtD.
  - Register 0 never causes a stall.
  - E and M matching together stall if either condition holds.
- MD hazard:
  - md_busy = (busy_cnt!=0) || md_startE.
  - stall_md = md_instrD && md_busy.
- stall = stall_rs || stall_rt || stall_md.
- Outputs, combinational, zero latency:
  - pc_en = ifid_en = !stall.
  - idex_clr = stall.
- busy_cnt update each posedge (not in reset):
  - md_startE=1: load DIV_CYCLES if md_is_divE, else MULT_CYCLES.
  - Else if busy_cnt!=0: decrement by 1.
  - Else hold 0.
- Start while busy: cannot occur in legal sequences, because a stalled MD instruction never reaches E. If it does, the reload wins.
- stall_cnt increments by 1 on each posedge with stall=1 and reset=0, and holds at 0xFFFFFFFF.
- md_instrD entering D on the same cycle as md_startE stalls, because md_busy includes md_startE.
- After a mult start, busy_cnt runs 5,4,3,2,1,0. A D-stage MD instruction stalls for 6 cycles total: the start cycle plus 5.

Test Plan:
1. Reset, then all inputs 0 -> pc_en=1, ifid_en=1, idex_clr=0, md_busy=0, stall_cnt=0.
2. Load-use: rsD=8, tuse_rsD=0, a3E=8, tnewE=2 -> stall=1 (idex_clr=1, pc_en=0).
   - Next cycle a3E=0, a3M=8, tnewM=1 -> still stalls.
   - Then tnewM=0 -> released; stall_cnt=2.
3. Register-0 and no-hazard cases:
   - rsD=0, a3E=0, tuse_rsD=0, tnewE=2 -> no stall.
   - rtD=9, tuse_rtD=1, a3E=9, tnewE=1 -> no stall (forwardable).
4. Mult busy: md_startE=1, md_is_divE=0 for one cycle with md_instrD=1 held.
   - Stall for exactly 6 cycles; md_busy falls after 6 cycles.
   - A non-MD instruction (md_instrD=0) in the same window -> no stall.
5. Div busy: same as case 4 with md_is_divE=1 -> 11 stall cycles.
   - Assert reset after 4 of them -> busy_cnt=0, stall deasserts the cycle after reset, stall_cnt=0.
6. Saturation: force stall_cnt near 0xFFFFFFFE (hierarchical deposit), hold stall for 3 cycles -> stall_cnt reaches 0xFFFFFFFF and stays there.
